aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES-128 key-expansion engine feeding the 128-bit round-key operand of the combinational encryption round. It loads a cipher key, presents round key 0 (whitening key), and then computes one new round key per `next` request, up to round key 10. It also drives the round's `finalRound` control, so a round sequencer can pair each round-key step with one pass through the round datapath.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: load `key_in` and begin a key sequence; accepted only in IDLE.
- `key_in` in 128: cipher key; byte 0 at [127:120], word w0 = [127:96].
- `next` in 1: advance to the next round key; honoured only while `rk_valid`=1.
- `reverse` in 1: present only with `AES_KEYSCHED_REV_EN`; sampled with `start`.
- `rk_out` out 128: current round key; byte order matches `key_in` (column-major, byte 0 at MSB).
- `rk_valid` out 1: `rk_out` holds a valid round key.
- `round_idx` out 4: index of the key on `rk_out`, range 0..10.
- `final_round` out 1: `rk_out` is the last key of the current sequence.
- `busy` out 1: a sequence is in progress; high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sequence ends.

## Operation
- States:
  - IDLE: waiting for `start`.
  - FWD: serving keys in forward order.
  - FILL: macro only; building the key cache.
  - REV: macro only; serving keys in reverse order.
- IDLE + `start` (forward): latch the key, `round_idx`=0, `rk_out`=`key_in`, `rk_valid`=1, go to FWD.
- Expansion step, from current words w0..w3 and round r:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r+1],24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. All arithmetic is GF(2^8) XOR; no carries.
- FWD + `next` with `round_idx`<10: register the expanded key and increment `round_idx`.
- FWD + `next` with `round_idx`=10: pulse `done`, clear `rk_valid`/`final_round`, go to IDLE. `rk_out` and `round_idx` keep their last values.
- `final_round` = (`round_idx`==10) in FWD.
- Boundary conditions:
  - `start` while `busy`: ignored.
  - `next` while `rk_valid`=0: ignored.
  - `start` and `next` in the same IDLE cycle: `start` wins and `next` is dropped.
  - `key_in` is sampled only on the accepted `start` cycle.
  - Holding `next` high advances one key per cycle.
- Reset is asynchronous and may arrive mid-sequence: all outputs return to their reset values immediately and the FSM goes to IDLE. No key state is retained.

## Timing
- Reset values: `rk_out`=0, `rk_valid`=0, `round_idx`=0, `final_round`=0, `busy`=0, `done`=0.
- Accepted `start` at cycle N: key 0 is on `rk_out` with `rk_valid`=1 at N+1.
- `next` accepted at cycle M: key r+1 is on `rk_out` at M+1. Latency is 1 cycle; `rk_valid` stays high between keys.
- A full forward sequence is 12 cycles with `next` held high: 1 load cycle, 10 steps, 1 terminating `next`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `AES_KEYSCHED_REV_EN` defined: adds the `reverse` port and an 11×128-bit key cache.
  - `start` with `reverse`=1 enters FILL: keys 0..10 are written to the cache one per cycle, with `busy`=1 and `rk_valid`=0.
  - REV then presents key 10 with `rk_valid`=1 at `start`+12.
  - Each `next` presents the cache entry at `round_idx`−1.
  - `final_round` = (`round_idx`==0) in REV.
  - `next` at index 0 pulses `done` and returns to IDLE.
  - `start` with `reverse`=0 behaves exactly as the forward mode.
- Undefined: no `reverse` port, no cache, no FILL/REV states; forward only.

## Structure
- Shared package `aes_pkg`:
  - 256-entry S-box constant and `sbox` function.
  - Rcon table.
  - FSM state enum.
  - `NR`=10 constant.
- Sub-module `aes_sub_word`: combinational, 32-bit in/out, four S-box lookups; instantiated once for SubWord.
- The cache (macro builds only) is a plain register array inside the top module.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c + `start`:
  - next cycle `rk_out`=that key, `round_idx`=0.
  - One `next` -> a0fafe1788542cb123a339392a6c7605, `round_idx`=1.
- Same key, `next` held high: round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6 with `final_round`=1; the following cycle `done`=1, `rk_valid`=0, `busy`=0.
- Second `start` and `next` pulses during FWD: `start` is ignored; `next` gaps of 0–5 cycles give the same key sequence.
- `rst_n` low at `round_idx`=5: outputs are 0 immediately. A new `start` with key 000102030405060708090a0b0c0d0e0f yields d6aa74fdd2af72fadaa678f1d6ab76fe at round 1.
- `start` and `next` asserted together in IDLE: `round_idx`=0 next cycle, not 1.
- `AES_KEYSCHED_REV_EN`, FIPS key, `reverse`=1:
  - `rk_valid` rises at `start`+12 with the round-10 key.
  - 10 `next`s walk keys down to the original key with `final_round`=1.
  - The 11th `next` pulses `done`.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants for the key-schedule slice.
//   SBOX / sbox()  : forward AES S-box table and byte lookup helper.
//   rcon()         : round constant Rcon[1..10] (0 outside that range).
//   NR             : number of rounds (10 for AES-128).
//   ksState_e      : key-schedule FSM states. FILL/REV exist only when
//                    AES_KEYSCHED_REV_EN is defined.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for the step that produces round key r.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_KEYSCHED_REV_EN
  typedef enum logic [1:0] {IDLE, FWD, FILL, REV} ksState_e;
`else
  typedef enum logic [1:0] {IDLE, FWD} ksState_e;
`endif

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: AES SubWord, four parallel S-box lookups (combinational).
//   word    in  32 : input word, byte 0 at [31:24]
//   subWord out 32 : S-box applied to every byte, same byte order
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subWord
);

  for (genvar gi = 0; gi < 4; gi++) begin : gByte
    assign subWord[gi*8 +: 8] = sbox(word[gi*8 +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one round key per
// accepted `next`, plus the finalRound control for the round datapath.
// Optional feature macro: AES_KEYSCHED_REV_EN (reverse-order key delivery
// through an 11-entry key cache filled before the first key is presented).
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load key_in and begin a sequence (IDLE only)
//   reverse     : (macro builds) serve keys 10..0 instead of 0..10
//   key_in      : cipher key, byte 0 at [127:120]
//   next        : advance one round key while rk_valid=1
//   rk_out      : current round key
//   rk_valid    : rk_out holds a valid key
//   round_idx   : index of the key on rk_out
//   final_round : rk_out is the last key of the sequence
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse at the end of a sequence
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef AES_KEYSCHED_REV_EN
  input  logic         reverse,
`endif
  input  logic [127:0] key_in,
  input  logic         next,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic [3:0]   round_idx,
  output logic         final_round,
  output logic         busy,
  output logic         done
);

  ksState_e    state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] subOut, tWord;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] expKey;

  // The expansion always works from the key currently on rk_out; in FILL
  // rk_out doubles as the working register while rk_valid is low.
  assign {w0, w1, w2, w3} = rk_out;

  aes_sub_word uSubWord (
    .word    ({w3[23:0], w3[31:24]}),
    .subWord (subOut)
  );

  assign tWord  = subOut ^ {rcon(round_idx + 4'd1), 24'h000000};
  assign n0     = w0 ^ tWord;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign expKey = {n0, n1, n2, n3};

`ifdef AES_KEYSCHED_REV_EN
  logic [127:0] keyCache [0:10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) keyCache[i] <= '0;
    end else if (state == FILL) begin
      keyCache[round_idx] <= rk_out;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rk_out      <= '0;
      rk_valid    <= 1'b0;
      round_idx   <= '0;
      final_round <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start has priority; a simultaneous next is simply not looked at
          if (start) begin
            rk_out      <= key_in;
            round_idx   <= '0;
            final_round <= 1'b0;
            busy        <= 1'b1;
`ifdef AES_KEYSCHED_REV_EN
            if (reverse) begin
              state    <= FILL;
              rk_valid <= 1'b0;
            end else
`endif
            begin
              state    <= FWD;
              rk_valid <= 1'b1;
            end
          end
        end

        FWD: begin
          if (next) begin
            if (round_idx == NR) begin
              state       <= IDLE;
              done        <= 1'b1;
              rk_valid    <= 1'b0;
              final_round <= 1'b0;
              busy        <= 1'b0;
            end else begin
              rk_out      <= expKey;
              round_idx   <= round_idx + 4'd1;
              final_round <= (round_idx == NR - 4'd1);
            end
          end
        end

`ifdef AES_KEYSCHED_REV_EN
        // Cache write of the current key happens in the block above; the
        // last key stays on rk_out and becomes the first key served.
        FILL: begin
          if (round_idx == NR) begin
            state    <= REV;
            rk_valid <= 1'b1;
          end else begin
            rk_out    <= expKey;
            round_idx <= round_idx + 4'd1;
          end
        end

        REV: begin
          if (next) begin
            if (round_idx == 4'd0) begin
              state       <= IDLE;
              done        <= 1'b1;
              rk_valid    <= 1'b0;
              final_round <= 1'b0;
              busy        <= 1'b0;
            end else begin
              rk_out      <= keyCache[round_idx - 4'd1];
              round_idx   <= round_idx - 4'd1;
              final_round <= (round_idx == 4'd1);
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed self-checking bench for aes_key_schedule
// using the FIPS-197 A.1 key expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         reverse;
  logic [127:0] key_in;
  logic         next;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [3:0]   round_idx;
  logic         final_round;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef AES_KEYSCHED_REV_EN
    .reverse     (reverse),
`endif
    .key_in      (key_in),
    .next        (next),
    .rk_out      (rk_out),
    .rk_valid    (rk_valid),
    .round_idx   (round_idx),
    .final_round (final_round),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_rk_out"},    rk_out,      128'h0);
    check({tag, "_rk_valid"},  rk_valid,    128'h0);
    check({tag, "_round_idx"}, round_idx,   128'h0);
    check({tag, "_final"},     final_round, 128'h0);
    check({tag, "_busy"},      busy,        128'h0);
    check({tag, "_done"},      done,        128'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    reverse = 1'b0;
    next    = 1'b0;
    key_in  = '0;
    repeat (2) tick();
    checkIdleOutputs("reset");
    $display("txn reset: outputs cleared");
    rst_n = 1'b1;
    tick();

    // Load FIPS key, then scramble key_in to show it is not resampled.
    key_in = fips[0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = 128'hdeadbeef_00000000_11111111_22222222;
    check("load_rk", rk_out, fips[0]);
    check("load_idx", round_idx, 128'd0);
    check("load_valid", rk_valid, 128'd1);
    check("load_busy", busy, 128'd1);
    $display("txn load: rk=%h idx=%0d", rk_out, round_idx);

    // Steps with 0..5 idle cycles between next pulses; start pulses in the
    // gaps must be ignored.
    for (int r = 1; r <= 10; r++) begin
      for (int g = 0; g < (r % 6); g++) begin
        start  = (g == 0);
        key_in = KEY2;
        tick();
        start = 1'b0;
        check($sformatf("gap_hold_r%0d", r), rk_out, fips[r-1]);
      end
      next = 1'b1;
      tick();
      next = 1'b0;
      check($sformatf("fwd_rk_r%0d", r), rk_out, fips[r]);
      check($sformatf("fwd_idx_r%0d", r), round_idx, 128'(r));
      check($sformatf("fwd_final_r%0d", r), final_round, 128'(r == 10));
      $display("txn fwd: idx=%0d rk=%h final=%0d", round_idx, rk_out, final_round);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    check("end_done", done, 128'd1);
    check("end_valid", rk_valid, 128'd0);
    check("end_busy", busy, 128'd0);
    check("end_final", final_round, 128'd0);
    check("end_rk_keep", rk_out, fips[10]);
    check("end_idx_keep", round_idx, 128'd10);
    tick();
    check("done_pulse_clear", done, 128'd0);
    $display("txn end: done pulse seen");

    // Held-high next: one key per cycle.
    key_in = fips[0];
    start  = 1'b1;
    tick();
    start = 1'b0;
    next  = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      tick();
      check($sformatf("held_rk_r%0d", r), rk_out, fips[r]);
    end
    check("held_final", final_round, 128'd1);
    tick();
    check("held_done", done, 128'd1);
    check("held_valid", rk_valid, 128'd0);
    check("held_busy", busy, 128'd0);
    tick();
    check("idle_next_ignored_idx", round_idx, 128'd10);
    check("idle_next_no_done", done, 128'd0);
    next = 1'b0;
    $display("txn held: full sequence done");

    // start + next together in IDLE: start wins.
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    next  = 1'b0;
    check("startnext_idx", round_idx, 128'd0);
    check("startnext_rk", rk_out, fips[0]);
    $display("txn start+next: idx=%0d", round_idx);

    // Advance to round 5, then reset asynchronously between clock edges.
    next = 1'b1;
    repeat (5) tick();
    next = 1'b0;
    check("pre_rst_idx", round_idx, 128'd5);
    #2 rst_n = 1'b0;
    #1;
    checkIdleOutputs("async_rst");
    $display("txn async reset at idx 5");
    tick();
    rst_n = 1'b1;
    tick();

    key_in = KEY2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("key2_r0", rk_out, KEY2);
    next = 1'b1;
    tick();
    next = 1'b0;
    check("key2_r1", rk_out, KEY2_R1);
    check("key2_idx", round_idx, 128'd1);
    $display("txn key2: rk=%h", rk_out);

`ifdef AES_KEYSCHED_REV_EN
    // Finish the KEY2 sequence, then run the reverse walk.
    next = 1'b1;
    repeat (10) tick();
    next = 1'b0;
    check("key2_done", done, 128'd1);
    tick();

    key_in  = fips[0];
    start   = 1'b1;
    reverse = 1'b1;
    tick();
    start   = 1'b0;
    reverse = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("fill_valid_c%0d", c), rk_valid, 128'd0);
      check($sformatf("fill_busy_c%0d", c), busy, 128'd1);
      tick();
    end
    check("rev_first_valid", rk_valid, 128'd1);
    check("rev_first_rk", rk_out, fips[10]);
    check("rev_first_idx", round_idx, 128'd10);
    check("rev_first_final", final_round, 128'd0);
    for (int r = 9; r >= 0; r--) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      check($sformatf("rev_rk_r%0d", r), rk_out, fips[r]);
      check($sformatf("rev_final_r%0d", r), final_round, 128'(r == 0));
      $display("txn rev: idx=%0d rk=%h", round_idx, rk_out);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    check("rev_done", done, 128'd1);
    check("rev_busy", busy, 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
